main_mem_responder: RTL and testbench

//   Main-memory model on the memory side of the cache<->memory interface; answers the cache's word requests.

---
 rtl/main_mem_responder_if.sv | 24 ++
 rtl/main_mem_responder.sv | 115 +++++++++++
 tb/tb_main_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Cache<->memory request/response bundle. The cache drives requests through the
// master modport; the memory model answers through the slave modport.
interface main_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              memEnable;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memDataIn;
  logic [DATA_W-1:0] memDataOut;
  logic              memValid;
  logic              memBusy;

  modport master (
    output memEnable, memWrite, memAddress, memDataIn,
    input  memDataOut, memValid, memBusy
  );

  modport slave (
    input  memEnable, memWrite, memAddress, memDataIn,
    output memDataOut, memValid, memBusy
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model: one word request at a time, completion pulsed
// on memValid LATENCY cycles after the request is sampled.
module main_mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic                   write_q, write_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   mem_we;
  logic [DEPTH_LOG2-1:0]  req_idx;

  // Storage deliberately has no reset so contents survive a reset pulse.
  logic [DATA_W-1:0]      mem [DEPTH];

  // Byte address to word index; bit 0 and bits above the array range alias away.
  assign req_idx = bus.memAddress[DEPTH_LOG2:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.memAddress[ADDR_W-1:DEPTH_LOG2+1], bus.memAddress[0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.memEnable && rst) begin
          idx_d   = req_idx;
          write_d = bus.memWrite;
          cnt_d   = CNT_INIT;
          mem_we  = bus.memWrite;
          if (LATENCY == 1) begin
            state_d = RESP;
            // Single-cycle latency: the latched index is not yet available.
            if (!bus.memWrite) begin
              data_out_d = mem[req_idx];
            end
          end else begin
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = RESP;
          if (!write_q) begin
            data_out_d = mem[idx_q];
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      data_out_q <= data_out_d;
    end
  end

  // Writes commit on the sample edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= bus.memDataIn;
    end
  end

  assign bus.memValid   = (state_q == RESP);
  assign bus.memBusy    = (state_q != IDLE);
  assign bus.memDataOut = data_out_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: LATENCY=4 instance for most scenarios, a
// LATENCY=1 instance for aliasing and alternate-cycle responses.
module tb_main_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference: word arrays keyed by word index, plus the last read value returned.
  logic [15:0] ref_a [int];
  logic [15:0] ref_b [int];
  logic [15:0] last_out_a = 16'h0000;
  logic [15:0] last_out_b = 16'h0000;

  main_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  main_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  main_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LATENCY(LAT_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  main_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LATENCY(LAT_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 4096;
  endfunction

  task automatic req_a(input bit w, input logic [15:0] addr, input logic [15:0] d, input string name);
    int n;
    logic [15:0] exp;
    bus_a.memEnable  = 1'b1;
    bus_a.memWrite   = w;
    bus_a.memAddress = addr;
    bus_a.memDataIn  = d;
    @(posedge clk); #1;
    if (w) ref_a[widx(addr)] = d;
    else   last_out_a = ref_a[widx(addr)];
    exp = last_out_a;
    bus_a.memEnable  = 1'b0;
    bus_a.memWrite   = 1'($urandom);
    bus_a.memAddress = 16'($urandom);
    bus_a.memDataIn  = 16'($urandom);
    n = 1;
    while (!bus_a.memValid && n < 20) begin
      checks++;
      if (bus_a.memBusy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b expected 1 at edge %0d", name, bus_a.memBusy, n);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== LAT_A) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, LAT_A);
    end
    checks++;
    if (bus_a.memDataOut !== exp) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, bus_a.memDataOut, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_a.memValid !== 1'b0 || bus_a.memBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse end: got valid=%b busy=%b expected 0 0", name, bus_a.memValid, bus_a.memBusy);
    end
  endtask

  task automatic req_b(input bit w, input logic [15:0] addr, input logic [15:0] d, input string name);
    bus_b.memEnable  = 1'b1;
    bus_b.memWrite   = w;
    bus_b.memAddress = addr;
    bus_b.memDataIn  = d;
    @(posedge clk); #1;
    if (w) ref_b[widx(addr)] = d;
    else   last_out_b = ref_b[widx(addr)];
    bus_b.memEnable = 1'b0;
    checks++;
    if (bus_b.memValid !== 1'b1 || bus_b.memDataOut !== last_out_b) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", name, bus_b.memValid, bus_b.memDataOut, last_out_b);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_b.memValid !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse end: got %b expected 0", name, bus_b.memValid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.memEnable = 1'b0; bus_a.memWrite = 1'b0; bus_a.memAddress = '0; bus_a.memDataIn = '0;
    bus_b.memEnable = 1'b0; bus_b.memWrite = 1'b0; bus_b.memAddress = '0; bus_b.memDataIn = '0;
    #2;
    checks++;
    if (bus_a.memValid !== 1'b0 || bus_a.memBusy !== 1'b0 || bus_a.memDataOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_a: got valid=%b busy=%b data=%h expected 0 0 0000", bus_a.memValid, bus_a.memBusy, bus_a.memDataOut);
    end
    checks++;
    if (bus_b.memValid !== 1'b0 || bus_b.memBusy !== 1'b0 || bus_b.memDataOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_b: got valid=%b busy=%b data=%h expected 0 0 0000", bus_b.memValid, bus_b.memBusy, bus_b.memDataOut);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    req_a(1'b1, 16'h1234, 16'hABCD, "wr_1234");
    req_a(1'b0, 16'h1234, 16'h0000, "rd_1234");
  endtask

  task automatic test_line_fill();
    logic [15:0] vals [8];
    int cyc, last, k;
    vals = '{16'hABCD, 16'hABCE, 16'hABCF, 16'hABA0, 16'hABA1, 16'hABA2, 16'hABA3, 16'hABA4};
    for (int i = 0; i < 8; i++) req_a(1'b1, 16'(16'h1240 + 2 * i), vals[i], "fill_wr");
    bus_a.memEnable  = 1'b1;
    bus_a.memWrite   = 1'b0;
    bus_a.memAddress = 16'h1240;
    k = 0; cyc = 0; last = 0;
    while (k < 8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus_a.memValid) begin
        checks++;
        if (bus_a.memDataOut !== vals[k]) begin
          errors++;
          $display("FAIL fill_data[%0d]: got %h expected %h", k, bus_a.memDataOut, vals[k]);
        end
        checks++;
        if ((k == 0 && cyc != LAT_A) || (k != 0 && cyc - last != LAT_A + 1)) begin
          errors++;
          $display("FAIL fill_spacing[%0d]: got cycle %0d after previous %0d", k, cyc, last);
        end
        last = cyc;
        k++;
        if (k < 8) bus_a.memAddress = 16'(16'h1240 + 2 * k);
        else       bus_a.memEnable = 1'b0;
      end
    end
    bus_a.memEnable = 1'b0;
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL fill_count: got %0d pulses expected 8", k);
    end
    last_out_a = vals[7];
    @(posedge clk); #1;
  endtask

  task automatic test_churn();
    int n;
    req_a(1'b1, 16'h2000, 16'h5A5A, "churn_prewrite");
    bus_a.memEnable  = 1'b1;
    bus_a.memWrite   = 1'b0;
    bus_a.memAddress = 16'h1234;
    @(posedge clk); #1;
    bus_a.memAddress = 16'h2000;
    bus_a.memWrite   = 1'b1;
    bus_a.memDataIn  = 16'hFFFF;
    n = 1;
    while (!bus_a.memValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus_a.memEnable = 1'b0;
    last_out_a = ref_a[widx(16'h1234)];
    checks++;
    if (n !== LAT_A || bus_a.memDataOut !== last_out_a) begin
      errors++;
      $display("FAIL churn_resp: got n=%0d data=%h expected n=%0d data=%h", n, bus_a.memDataOut, LAT_A, last_out_a);
    end
    @(posedge clk); #1;
    req_a(1'b0, 16'h2000, 16'h0000, "churn_readback");
  endtask

  task automatic test_random();
    logic [15:0] addrs [$];
    logic [15:0] a;
    for (int i = 0; i < 24; i++) begin
      if (addrs.size() == 0 || $urandom_range(0, 2) == 0) begin
        a = 16'($urandom);
        addrs.push_back(a);
        req_a(1'b1, a, 16'($urandom), "rand_wr");
      end else begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        // Same word through a different alias: flip bit 0 and the unused upper bits.
        a = {3'($urandom), a[12:1], 1'($urandom)};
        req_a(1'b0, a, 16'h0000, "rand_rd");
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    seen = 0;
    bus_a.memEnable  = 1'b1;
    bus_a.memWrite   = 1'b0;
    bus_a.memAddress = 16'h1234;
    @(posedge clk); #1;
    bus_a.memEnable = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a.memValid !== 1'b0 || bus_a.memBusy !== 1'b0 || bus_a.memDataOut !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: got valid=%b busy=%b data=%h expected 0 0 0000", bus_a.memValid, bus_a.memBusy, bus_a.memDataOut);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    last_out_a = 16'h0000;
    last_out_b = 16'h0000;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_a.memValid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_pulse: got %0d pulses expected 0", seen);
    end
    req_a(1'b0, 16'h1234, 16'h0000, "midreset_read");
  endtask

  task automatic test_latency1();
    logic exp;
    req_b(1'b1, 16'h1234, 16'hABCD, "l1_wr");
    req_b(1'b0, 16'h1235, 16'h0000, "l1_alias_1235");
    req_b(1'b0, 16'h3234, 16'h0000, "l1_alias_3234");
    bus_b.memEnable  = 1'b1;
    bus_b.memWrite   = 1'b0;
    bus_b.memAddress = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = (i % 2 == 0);
      checks++;
      if (bus_b.memValid !== exp) begin
        errors++;
        $display("FAIL l1_toggle[%0d]: got %b expected %b", i, bus_b.memValid, exp);
      end
    end
    bus_b.memEnable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_line_fill();
    test_churn();
    test_random();
    test_reset_mid_busy();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
